// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the two requester ports and the memory pins around mem_bus_arbiter.
// The slave modport is the arbiter's view; master is the view of the requesters plus memory.
interface mem_bus_arbiter_if #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 16
);
  logic          a_req;
  logic          a_rdwr;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_lock;
  logic          a_gnt;
  logic          a_ack;
  logic [DW-1:0] a_rdata;

  logic          b_req;
  logic          b_rdwr;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt;
  logic          b_ack;
  logic [DW-1:0] b_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_rdwr;
  logic          mem_en;
  logic          owner;
  logic          busy;

  modport slave (
    input  a_req, a_rdwr, a_addr, a_wdata, a_lock,
    input  b_req, b_rdwr, b_addr, b_wdata,
    input  mem_rdata,
    output a_gnt, a_ack, a_rdata,
    output b_gnt, b_ack, b_rdata,
    output mem_addr, mem_wdata, mem_rdwr, mem_en, owner, busy
  );

  modport master (
    output a_req, a_rdwr, a_addr, a_wdata, a_lock,
    output b_req, b_rdwr, b_addr, b_wdata,
    output mem_rdata,
    input  a_gnt, a_ack, a_rdata,
    input  b_gnt, b_ack, b_rdata,
    input  mem_addr, mem_wdata, mem_rdwr, mem_en, owner, busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter in front of the shared program/data memory: fixed-latency access window,
// round-robin or fixed priority, and a CPU lock that chains back-to-back port A accesses.
module mem_bus_arbiter #(
  parameter int unsigned AW         = 12,
  parameter int unsigned DW         = 16,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic             clkin,
  input  logic             rst,
  mem_bus_arbiter_if.slave bus
);
  localparam int unsigned   CW       = 4;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic          a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic          mem_en_q, mem_en_d, mem_rdwr_q, mem_rdwr_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic          start, win_b;

  // State and output registers; reset also aborts an in-flight access
  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b1;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_rdwr_q  <= 1'b1;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      a_gnt_q     <= a_gnt_d;
      b_gnt_q     <= b_gnt_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      mem_en_q    <= mem_en_d;
      mem_rdwr_q  <= mem_rdwr_d;
      busy_q      <= busy_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

  // Next-state, arbitration and access sequencing
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    a_gnt_d     = 1'b0;
    b_gnt_d     = 1'b0;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    mem_en_d    = mem_en_q;
    mem_rdwr_d  = mem_rdwr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    start       = 1'b0;
    win_b       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.a_req || bus.b_req) begin
          start = 1'b1;
          // On a tie in round-robin mode the port that did not own the bus last goes next
          win_b = bus.b_req && (!bus.a_req || ((FIXED_PRIO == 0) && !owner_q));
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          if (mem_rdwr_q) begin
            if (owner_q) b_rdata_d = bus.mem_rdata;
            else         a_rdata_d = bus.mem_rdata;
          end
          a_ack_d  = !owner_q;
          b_ack_d  = owner_q;
          mem_en_d = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (!owner_q && bus.a_lock && bus.a_req) start = 1'b1;
        else                                     state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d     = ACCESS;
      cnt_d       = CNT_INIT;
      owner_d     = win_b;
      a_gnt_d     = !win_b;
      b_gnt_d     = win_b;
      mem_en_d    = 1'b1;
      mem_rdwr_d  = win_b ? bus.b_rdwr  : bus.a_rdwr;
      mem_addr_d  = win_b ? bus.b_addr  : bus.a_addr;
      mem_wdata_d = win_b ? bus.b_wdata : bus.a_wdata;
    end

    busy_d = (state_d != IDLE);
  end

  assign bus.a_gnt     = a_gnt_q;
  assign bus.b_gnt     = b_gnt_q;
  assign bus.a_ack     = a_ack_q;
  assign bus.b_ack     = b_ack_q;
  assign bus.a_rdata   = a_rdata_q;
  assign bus.b_rdata   = b_rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_rdwr  = mem_rdwr_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations plus random traffic,
// all checked every cycle against a transaction-timing model of the arbiter.
module tb_mem_bus_arbiter;
  localparam int unsigned AW      = 12;
  localparam int unsigned DW      = 16;
  localparam int unsigned MEM_LAT = 2;
  localparam int unsigned DEPTH   = 1 << AW;

  logic clkin = 1'b0;
  logic rst   = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  mem_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  mem_bus_arbiter_if #(.AW(AW), .DW(DW)) bus2 ();

  mem_bus_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .FIXED_PRIO(0)) dut (
    .clkin(clkin), .rst(rst), .bus(bus));
  mem_bus_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .FIXED_PRIO(1)) dut_fp (
    .clkin(clkin), .rst(rst), .bus(bus2));

  always #5 clkin = ~clkin;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 12'h010) return 16'h1234;
    if (a == 12'h020) return 16'h0041;
    if (a == 12'h7FF) return 16'h0000;
    return DW'(32'(a) * 37 + 5);
  endfunction

  // Memory with combinational read, written at each edge where a write is enabled
  logic [DW-1:0] mem [DEPTH];
  assign bus.mem_rdata  = mem[bus.mem_addr];
  assign bus2.mem_rdata = 16'h5A5A;
  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = init_val(AW'(i));
    forever begin
      @(posedge clkin);
      if (bus.mem_en && !bus.mem_rdwr) mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  // Reference model: tracks one transaction by its grant edge and completion edge
  logic          e_agnt = 1'b0, e_bgnt = 1'b0, e_aack = 1'b0, e_back = 1'b0;
  logic          e_en = 1'b0, e_rdwr = 1'b1, e_owner = 1'b1, e_busy = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_ardata = '0, e_brdata = '0;

  initial begin : model
    logic [DW-1:0] shadow [DEPTH];
    int            n, t_start, t_done;
    bit            act, port_b, rd, start, win_b;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    for (int i = 0; i < int'(DEPTH); i++) shadow[i] = init_val(AW'(i));
    n = 0; t_start = 0; t_done = -100; act = 1'b0; port_b = 1'b0; rd = 1'b1;
    addr = '0; wd = '0;
    forever begin
      @(posedge clkin or negedge rst);
      if (!rst) begin
        act = 1'b0; t_done = -100;
        e_agnt = 1'b0; e_bgnt = 1'b0; e_aack = 1'b0; e_back = 1'b0;
        e_en = 1'b0; e_rdwr = 1'b1; e_owner = 1'b1; e_busy = 1'b0;
        e_addr = '0; e_wdata = '0; e_ardata = '0; e_brdata = '0;
      end else begin
        n++;
        e_agnt = 1'b0; e_bgnt = 1'b0; e_aack = 1'b0; e_back = 1'b0;
        start = 1'b0; win_b = 1'b0;
        if (act && !rd) shadow[addr] = wd;
        if (act && n == t_start + int'(MEM_LAT)) begin
          if (rd) begin
            if (port_b) e_brdata = shadow[addr];
            else        e_ardata = shadow[addr];
          end
          e_aack = !port_b; e_back = port_b;
          act = 1'b0; t_done = n;
        end else if (!act) begin
          if (n == t_done + 1 && !e_owner && bus.a_lock && bus.a_req) begin
            start = 1'b1;
          end else if (n >= t_done + 2 && (bus.a_req || bus.b_req)) begin
            start = 1'b1;
            if (bus.a_req && bus.b_req) win_b = (e_owner == 1'b0);
            else                        win_b = bus.b_req;
          end
        end
        if (start) begin
          act = 1'b1; t_start = n; port_b = win_b;
          rd   = win_b ? bus.b_rdwr  : bus.a_rdwr;
          addr = win_b ? bus.b_addr  : bus.a_addr;
          wd   = win_b ? bus.b_wdata : bus.a_wdata;
          e_owner = win_b; e_agnt = !win_b; e_bgnt = win_b;
          e_addr = addr; e_wdata = wd; e_rdwr = rd;
        end
        e_en   = act;
        e_busy = act || (n == t_done);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic compare_all();
    if (rst) begin
      chk("a_gnt",     32'(bus.a_gnt),     32'(e_agnt));
      chk("b_gnt",     32'(bus.b_gnt),     32'(e_bgnt));
      chk("a_ack",     32'(bus.a_ack),     32'(e_aack));
      chk("b_ack",     32'(bus.b_ack),     32'(e_back));
      chk("a_rdata",   32'(bus.a_rdata),   32'(e_ardata));
      chk("b_rdata",   32'(bus.b_rdata),   32'(e_brdata));
      chk("mem_addr",  32'(bus.mem_addr),  32'(e_addr));
      chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
      chk("mem_rdwr",  32'(bus.mem_rdwr),  32'(e_rdwr));
      chk("mem_en",    32'(bus.mem_en),    32'(e_en));
      chk("owner",     32'(bus.owner),     32'(e_owner));
      chk("busy",      32'(bus.busy),      32'(e_busy));
      chk("one_pulse", 32'($countones({bus.a_gnt, bus.b_gnt, bus.a_ack, bus.b_ack}) <= 1), 32'd1);
    end
  endtask

  task automatic tick();
    @(negedge clkin);
    cyc++;
    compare_all();
  endtask

  task automatic access(input bit pb, input bit rd, input logic [AW-1:0] ad,
                        input logic [DW-1:0] wd, output logic [DW-1:0] rdat);
    bit got;
    if (pb) begin bus.b_req = 1'b1; bus.b_rdwr = rd; bus.b_addr = ad; bus.b_wdata = wd; end
    else    begin bus.a_req = 1'b1; bus.a_rdwr = rd; bus.a_addr = ad; bus.a_wdata = wd; end
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      if (pb ? bus.b_ack : bus.a_ack) got = 1'b1;
    end
    chk("ack_timeout", 32'(got), 32'd1);
    rdat = pb ? bus.b_rdata : bus.a_rdata;
    if (pb) bus.b_req = 1'b0;
    else    bus.a_req = 1'b0;
  endtask

  // Random requester behaviour: issue, withdraw before grant, scramble after grant, re-request on ack
  bit pend [2];
  bit granted [2];

  task automatic new_req(input int p);
    logic          rd;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    rd = ($urandom_range(0, 1) == 1);
    ad = AW'(12'h100 + $urandom_range(0, 15));
    wd = DW'($urandom);
    if (p == 1) begin bus.b_rdwr = rd; bus.b_addr = ad; bus.b_wdata = wd; end
    else        begin bus.a_rdwr = rd; bus.a_addr = ad; bus.a_wdata = wd; end
  endtask

  task automatic rnd_step();
    for (int p = 0; p < 2; p++) begin
      bit g, k;
      g = (p == 1) ? bus.b_gnt : bus.a_gnt;
      k = (p == 1) ? bus.b_ack : bus.a_ack;
      if (g) granted[p] = 1'b1;
      if (k) begin
        granted[p] = 1'b0;
        pend[p] = ($urandom_range(0, 1) == 1);
        if (pend[p]) new_req(p);
      end else if (!pend[p]) begin
        if ($urandom_range(0, 9) < 4) begin pend[p] = 1'b1; new_req(p); end
      end else if (!granted[p]) begin
        if ($urandom_range(0, 19) == 0) pend[p] = 1'b0;
      end else begin
        new_req(p);
      end
      if (p == 1) bus.b_req = pend[p];
      else        bus.a_req = pend[p];
    end
    if ($urandom_range(0, 3) == 0) bus.a_lock = ($urandom_range(0, 1) == 1);
  endtask

  int            order [4];
  int            tg [4];
  int            ng, na, ta1, ta2, tb, acks, bmid, gt, t0, fa, fb;
  bit            got, done, sawack;
  logic [DW-1:0] rv;

  initial begin
    bus.a_req = 1'b0; bus.a_rdwr = 1'b1; bus.a_addr = '0; bus.a_wdata = '0; bus.a_lock = 1'b0;
    bus.b_req = 1'b0; bus.b_rdwr = 1'b1; bus.b_addr = '0; bus.b_wdata = '0;
    bus2.a_req = 1'b0; bus2.a_rdwr = 1'b1; bus2.a_addr = '0; bus2.a_wdata = '0; bus2.a_lock = 1'b0;
    bus2.b_req = 1'b0; bus2.b_rdwr = 1'b1; bus2.b_addr = '0; bus2.b_wdata = '0;

    // Reset values
    repeat (3) tick();
    chk("rst_mem_en",   32'(bus.mem_en),   32'd0);
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_mem_rdwr", 32'(bus.mem_rdwr), 32'd1);
    chk("rst_owner",    32'(bus.owner),    32'd1);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_a_rdata",  32'(bus.a_rdata),  32'd0);
    rst = 1'b1;

    // Single read of 0x010
    bus.a_req = 1'b1; bus.a_rdwr = 1'b1; bus.a_addr = 12'h010;
    tick();
    chk("rd_gnt",  32'(bus.a_gnt),    32'd1);
    chk("rd_en1",  32'(bus.mem_en),   32'd1);
    chk("rd_addr", 32'(bus.mem_addr), 32'h010);
    chk("rd_dir",  32'(bus.mem_rdwr), 32'd1);
    tick();
    chk("rd_en2",       32'(bus.mem_en), 32'd1);
    chk("rd_gnt_pulse", 32'(bus.a_gnt),  32'd0);
    tick();
    chk("rd_ack",    32'(bus.a_ack),   32'd1);
    chk("rd_en_off", 32'(bus.mem_en),  32'd0);
    chk("rd_data",   32'(bus.a_rdata), 32'h1234);
    bus.a_req = 1'b0;
    repeat (3) tick();
    chk("rd_hold", 32'(bus.a_rdata), 32'h1234);

    // B writes 0x7FF, A reads it back, B then reads 0x010
    access(1'b1, 1'b0, 12'h7FF, 16'h0ABC, rv);
    chk("bw_b_rdata", 32'(rv), 32'h0000);
    access(1'b0, 1'b1, 12'h7FF, 16'h0000, rv);
    chk("ar_data",    32'(rv),           32'h0ABC);
    chk("ar_mem",     32'(mem[12'h7FF]), 32'h0ABC);
    chk("ar_b_rdata", 32'(bus.b_rdata),  32'h0000);
    access(1'b1, 1'b1, 12'h010, 16'h0000, rv);
    chk("br_data", 32'(rv), 32'h1234);

    // Round-robin with both requests held
    for (int i = 0; i < 4; i++) begin order[i] = -1; tg[i] = -100; end
    ng = 0; na = 0;
    bus.a_req = 1'b1; bus.a_rdwr = 1'b1; bus.a_addr = 12'h010;
    bus.b_req = 1'b1; bus.b_rdwr = 1'b1; bus.b_addr = 12'h7FF;
    for (int k = 0; k < 60 && na < 4; k++) begin
      tick();
      if (bus.a_gnt || bus.b_gnt) begin
        if (ng < 4) begin order[ng] = int'(bus.b_gnt); tg[ng] = cyc; end
        ng++;
      end
      if (bus.a_ack || bus.b_ack) na++;
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    chk("rr_acks", 32'(na), 32'd4);
    for (int i = 0; i < 4; i++) chk("rr_order", 32'(order[i]), 32'(i % 2));
    for (int i = 1; i < 4; i++) chk("rr_spacing", 32'(tg[i] - tg[i-1]), 32'd4);
    repeat (2) tick();

    // Locked read-modify-write of 0x020 with B waiting
    ta1 = -1; ta2 = -1; tb = -1; acks = 0; bmid = 0; done = 1'b0; rv = '0;
    bus.b_req = 1'b1; bus.b_rdwr = 1'b1; bus.b_addr = 12'h010;
    bus.a_req = 1'b1; bus.a_lock = 1'b1; bus.a_rdwr = 1'b1; bus.a_addr = 12'h020;
    for (int k = 0; k < 60 && !done; k++) begin
      tick();
      if (bus.a_gnt) begin
        if (ta1 < 0) ta1 = cyc;
        else         ta2 = cyc;
      end
      if (bus.b_gnt) begin
        if (acks < 2) bmid++;
        else          tb = cyc;
      end
      if (bus.a_ack) begin
        acks++;
        if (acks == 1) begin
          rv = bus.a_rdata; bus.a_rdwr = 1'b0; bus.a_wdata = rv + 16'd1;
        end else begin
          bus.a_lock = 1'b0; bus.a_req = 1'b0;
        end
      end
      if (bus.b_ack) begin bus.b_req = 1'b0; done = 1'b1; end
    end
    chk("lk_done",     32'(done),        32'd1);
    chk("lk_read",     32'(rv),          32'h0041);
    chk("lk_chain",    32'(ta2 - ta1),   32'd3);
    chk("lk_no_b",     32'(bmid),        32'd0);
    chk("lk_b_after",  32'(tb - ta2),    32'd4);
    chk("lk_mem",      32'(mem[12'h020]), 32'h0042);
    tick();

    // Asynchronous reset during the first ACCESS cycle
    bus.a_req = 1'b1; bus.a_rdwr = 1'b1; bus.a_addr = 12'h010;
    tick();
    chk("ar_pre_gnt", 32'(bus.a_gnt), 32'd1);
    rst = 1'b0;
    #1;
    chk("ar_en",    32'(bus.mem_en),  32'd0);
    chk("ar_busy",  32'(bus.busy),    32'd0);
    chk("ar_gnt",   32'(bus.a_gnt),   32'd0);
    chk("ar_owner", 32'(bus.owner),   32'd1);
    chk("ar_rdata", 32'(bus.a_rdata), 32'd0);
    sawack = 1'b0;
    repeat (3) begin tick(); if (bus.a_ack) sawack = 1'b1; end
    chk("ar_no_ack", 32'(sawack), 32'd0);
    rst = 1'b1;
    got = 1'b0; gt = -1; t0 = cyc;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (bus.a_gnt) gt = cyc;
      if (bus.a_ack) got = 1'b1;
    end
    chk("ar_regrant",  32'(gt - t0),       32'd1);
    chk("ar_complete", 32'(got),           32'd1);
    chk("ar_data",     32'(bus.a_rdata),   32'h1234);
    bus.a_req = 1'b0;
    repeat (3) tick();

    // Fixed-priority instance: A takes every grant while it requests
    fa = 0; fb = 0;
    bus2.a_req = 1'b1; bus2.b_req = 1'b1;
    repeat (40) begin
      tick();
      if (bus2.a_gnt) fa++;
      if (bus2.b_gnt) fb++;
    end
    chk("fp_b_none",  32'(fb),             32'd0);
    chk("fp_a_min",   32'(fa >= 9),        32'd1);
    chk("fp_a_rdata", 32'(bus2.a_rdata),   32'h5A5A);
    bus2.a_req = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      tick();
      if (bus2.b_gnt) got = 1'b1;
    end
    chk("fp_b_after", 32'(got), 32'd1);
    bus2.b_req = 1'b0;

    // Random traffic against the model
    pend[0] = 1'b0; pend[1] = 1'b0; granted[0] = 1'b0; granted[1] = 1'b0;
    repeat (3000) begin
      rnd_step();
      tick();
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0; bus.a_lock = 1'b0;
    repeat (10) tick();
    chk("end_idle", 32'(bus.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
